// File: rtl/api_regbank_ctrl.sv
// Host register bank between the API FIFOs and a multi-cycle compute core:
// operand/result/control registers, start/done handshake, queued read replies.
module api_regbank_ctrl #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 8,
  parameter int SLOT_W     = 4,
  parameter int FPGA_W     = 4,
  parameter int CMD_W      = 4,
  parameter int N_IN       = 6,
  parameter int N_OUT      = 2,
  parameter int RQ_DEPTH   = 4,
  parameter int AUTO_START = 0,
  parameter logic [CMD_W-1:0] CMD_RD = CMD_W'(1),
  parameter logic [CMD_W-1:0] CMD_WR = CMD_W'(2)
) (
  input  logic                    reset,
  input  logic                    api_clk_in,
  input  logic                    api_i_empty_in,
  output logic                    api_i_rd_en_out,
  input  logic [SLOT_W-1:0]       api_i_src_slot_in,
  input  logic [FPGA_W-1:0]       api_i_src_fpga_in,
  input  logic [ADDR_W-1:0]       api_i_src_reg_in,
  input  logic [ADDR_W-1:0]       api_i_tgt_reg_in,
  input  logic [CMD_W-1:0]        api_i_tgt_cmd_in,
  input  logic [DATA_W-1:0]       api_i_data_in,
  input  logic                    api_o_rfd_in,
  output logic                    api_o_wr_en_out,
  output logic [SLOT_W-1:0]       api_o_tgt_slot_out,
  output logic [FPGA_W-1:0]       api_o_tgt_fpga_out,
  output logic [ADDR_W-1:0]       api_o_tgt_reg_out,
  output logic [ADDR_W-1:0]       api_o_src_reg_out,
  output logic [CMD_W-1:0]        api_o_tgt_cmd_out,
  output logic [CMD_W-1:0]        api_o_src_cmd_out,
  output logic [DATA_W-1:0]       api_o_data_out,
  output logic                    core_start,
  output logic [N_IN*DATA_W-1:0]  core_in,
  input  logic                    core_done,
  input  logic [N_OUT*DATA_W-1:0] core_out
);

  localparam int PTR_W = $clog2(RQ_DEPTH);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(N_IN + N_OUT);
  localparam logic [ADDR_W-1:0] LAST_IN   = ADDR_W'(N_IN - 1);
  localparam logic [PTR_W:0]    RQ_FULL   = (PTR_W + 1)'(RQ_DEPTH);

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [FPGA_W-1:0] fpga;
    logic [ADDR_W-1:0] req_reg;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] data;
  } rq_entry_t;

  typedef enum logic {S_IDLE, S_BUSY} core_state_t;

  logic [DATA_W-1:0] op_reg  [N_IN];
  logic [DATA_W-1:0] res_reg [N_OUT];
  rq_entry_t         rq_mem  [RQ_DEPTH];
  rq_entry_t         rq_head;
  logic [PTR_W-1:0]  rq_wptr, rq_rptr;
  logic [PTR_W:0]    rq_count;
  logic              rq_full, rq_empty, rq_push, rq_pop;

  logic accept, is_wr, is_rd, wr_ctrl;
  logic start_req, clr_req, done_evt, busy_pre, start_ok, start_bad;
  core_state_t state, state_nxt;
  logic busy;
  logic done_sticky, start_err, done_nxt, err_nxt;
  logic [7:0] run_cnt;
  logic [DATA_W-1:0] status_word, rd_data;

  // A head word is consumed only on a cycle without a pop pulse in flight.
  assign rq_full  = (rq_count == RQ_FULL);
  assign rq_empty = (rq_count == '0);
  assign accept   = !api_i_empty_in && !api_i_rd_en_out && !rq_full;
  assign is_wr    = accept && (api_i_tgt_cmd_in == CMD_WR);
  assign is_rd    = accept && (api_i_tgt_cmd_in == CMD_RD);
  assign wr_ctrl  = is_wr && (api_i_tgt_reg_in == CTRL_ADDR);

  assign start_req = (wr_ctrl && api_i_data_in[0]) ||
                     ((AUTO_START != 0) && is_wr && (api_i_tgt_reg_in == LAST_IN));
  assign clr_req   = wr_ctrl && api_i_data_in[1];

  // Completion is resolved before a same-cycle start, so that start sees an idle core.
  assign done_evt  = core_done && busy;
  assign busy_pre  = busy && !core_done;
  assign start_ok  = start_req && !busy_pre;
  assign start_bad = start_req && busy_pre;

  always_ff @(posedge api_clk_in or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_BUSY;
      S_BUSY:  if (done_evt && !start_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_BUSY);
  end

  always_comb begin
    done_nxt = done_sticky;
    err_nxt  = start_err;
    if (done_evt)  done_nxt = 1'b1;
    if (clr_req) begin
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
    end
    if (start_ok)  done_nxt = 1'b0;
    if (start_bad) err_nxt  = 1'b1;
  end

  always_comb begin
    status_word       = '0;
    status_word[0]    = busy;
    status_word[1]    = done_sticky;
    status_word[2]    = start_err;
    status_word[15:8] = run_cnt;
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_IN; k++)
      if (api_i_tgt_reg_in == ADDR_W'(k)) rd_data = op_reg[k];
    for (int k = 0; k < N_OUT; k++)
      if (api_i_tgt_reg_in == ADDR_W'(N_IN + k)) rd_data = res_reg[k];
    if (api_i_tgt_reg_in == CTRL_ADDR) rd_data = status_word;
  end

  always_ff @(posedge api_clk_in or posedge reset) begin
    if (reset) begin
      done_sticky <= 1'b0;
      start_err   <= 1'b0;
      run_cnt     <= '0;
      core_start  <= 1'b0;
    end else begin
      done_sticky <= done_nxt;
      start_err   <= err_nxt;
      core_start  <= start_ok;
      if (done_evt) run_cnt <= run_cnt + 8'd1;
    end
  end

  always_ff @(posedge api_clk_in or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_IN; k++) op_reg[k] <= '0;
    end else begin
      for (int k = 0; k < N_IN; k++)
        if (is_wr && (api_i_tgt_reg_in == ADDR_W'(k))) op_reg[k] <= api_i_data_in;
    end
  end

  always_ff @(posedge api_clk_in or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) res_reg[k] <= '0;
    end else if (done_evt) begin
      for (int k = 0; k < N_OUT; k++) res_reg[k] <= core_out[k*DATA_W +: DATA_W];
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_IN; g++) begin : g_core_in
      assign core_in[g*DATA_W +: DATA_W] = op_reg[g];
    end
  endgenerate

  always_ff @(posedge api_clk_in or posedge reset) begin
    if (reset) api_i_rd_en_out <= 1'b0;
    else       api_i_rd_en_out <= accept;
  end

  assign rq_push = is_rd;
  assign rq_pop  = !rq_empty && api_o_rfd_in && !api_o_wr_en_out;
  assign rq_head = rq_mem[rq_rptr];

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge api_clk_in) begin
    if (rq_push)
      rq_mem[rq_wptr] <= '{slot:     api_i_src_slot_in,
                           fpga:     api_i_src_fpga_in,
                           req_reg:  api_i_src_reg_in,
                           reg_addr: api_i_tgt_reg_in,
                           data:     rd_data};
  end

  always_ff @(posedge api_clk_in or posedge reset) begin
    if (reset) begin
      rq_wptr  <= '0;
      rq_rptr  <= '0;
      rq_count <= '0;
    end else begin
      if (rq_push) rq_wptr <= rq_wptr + 1'b1;
      if (rq_pop)  rq_rptr <= rq_rptr + 1'b1;
      case ({rq_push, rq_pop})
        2'b10:   rq_count <= rq_count + 1'b1;
        2'b01:   rq_count <= rq_count - 1'b1;
        default: rq_count <= rq_count;
      endcase
    end
  end

  always_ff @(posedge api_clk_in or posedge reset) begin
    if (reset) begin
      api_o_wr_en_out    <= 1'b0;
      api_o_tgt_slot_out <= '0;
      api_o_tgt_fpga_out <= '0;
      api_o_tgt_reg_out  <= '0;
      api_o_src_reg_out  <= '0;
      api_o_tgt_cmd_out  <= '0;
      api_o_src_cmd_out  <= '0;
      api_o_data_out     <= '0;
    end else begin
      api_o_wr_en_out <= rq_pop;
      if (rq_pop) begin
        api_o_tgt_slot_out <= rq_head.slot;
        api_o_tgt_fpga_out <= rq_head.fpga;
        api_o_tgt_reg_out  <= rq_head.req_reg;
        api_o_src_reg_out  <= rq_head.reg_addr;
        api_o_tgt_cmd_out  <= CMD_WR;
        api_o_src_cmd_out  <= CMD_WR;
        api_o_data_out     <= rq_head.data;
      end
    end
  end

endmodule

// File: tb/tb_api_regbank_ctrl.sv
// Self-checking bench: FIFO model on the input, reply scoreboard on the output.
module tb_api_regbank_ctrl;
  localparam logic [3:0] CMD_RD = 4'd1, CMD_WR = 4'd2, CMD_NOP = 4'hF;
  localparam logic [7:0] CTRL = 8'd8;

  logic         reset, api_clk_in;
  logic         api_i_empty_in, api_i_rd_en_out;
  logic [3:0]   api_i_src_slot_in, api_i_src_fpga_in, api_i_tgt_cmd_in;
  logic [7:0]   api_i_src_reg_in, api_i_tgt_reg_in;
  logic [63:0]  api_i_data_in;
  logic         api_o_rfd_in, api_o_wr_en_out;
  logic [3:0]   api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_cmd_out, api_o_src_cmd_out;
  logic [7:0]   api_o_tgt_reg_out, api_o_src_reg_out;
  logic [63:0]  api_o_data_out;
  logic         core_start, core_done;
  logic [383:0] core_in;
  logic [127:0] core_out;

  logic         empty_b, rd_en_b, wr_en_b, start_b;
  logic [7:0]   reg_b, oreg_b, osrc_b;
  logic [63:0]  data_b, odata_b;
  logic [3:0]   oslot_b, ofpga_b, otcmd_b, oscmd_b;
  logic [383:0] core_in_b;

  api_regbank_ctrl u_dut (
    .reset(reset), .api_clk_in(api_clk_in),
    .api_i_empty_in(api_i_empty_in), .api_i_rd_en_out(api_i_rd_en_out),
    .api_i_src_slot_in(api_i_src_slot_in), .api_i_src_fpga_in(api_i_src_fpga_in),
    .api_i_src_reg_in(api_i_src_reg_in), .api_i_tgt_reg_in(api_i_tgt_reg_in),
    .api_i_tgt_cmd_in(api_i_tgt_cmd_in), .api_i_data_in(api_i_data_in),
    .api_o_rfd_in(api_o_rfd_in), .api_o_wr_en_out(api_o_wr_en_out),
    .api_o_tgt_slot_out(api_o_tgt_slot_out), .api_o_tgt_fpga_out(api_o_tgt_fpga_out),
    .api_o_tgt_reg_out(api_o_tgt_reg_out), .api_o_src_reg_out(api_o_src_reg_out),
    .api_o_tgt_cmd_out(api_o_tgt_cmd_out), .api_o_src_cmd_out(api_o_src_cmd_out),
    .api_o_data_out(api_o_data_out),
    .core_start(core_start), .core_in(core_in), .core_done(core_done), .core_out(core_out)
  );

  api_regbank_ctrl #(.AUTO_START(1)) u_dut_auto (
    .reset(reset), .api_clk_in(api_clk_in),
    .api_i_empty_in(empty_b), .api_i_rd_en_out(rd_en_b),
    .api_i_src_slot_in(4'd0), .api_i_src_fpga_in(4'd0),
    .api_i_src_reg_in(8'd0), .api_i_tgt_reg_in(reg_b),
    .api_i_tgt_cmd_in(CMD_WR), .api_i_data_in(data_b),
    .api_o_rfd_in(1'b1), .api_o_wr_en_out(wr_en_b),
    .api_o_tgt_slot_out(oslot_b), .api_o_tgt_fpga_out(ofpga_b),
    .api_o_tgt_reg_out(oreg_b), .api_o_src_reg_out(osrc_b),
    .api_o_tgt_cmd_out(otcmd_b), .api_o_src_cmd_out(oscmd_b),
    .api_o_data_out(odata_b),
    .core_start(start_b), .core_in(core_in_b), .core_done(1'b0), .core_out(128'd0)
  );

  typedef struct {
    logic [3:0]  slot, fpga, cmd;
    logic [7:0]  src_reg, tgt_reg;
    logic [63:0] data;
  } word_t;
  typedef struct {
    logic [3:0]  slot, fpga;
    logic [7:0]  req_reg, reg_addr;
    logic [63:0] data;
  } reply_t;
  typedef struct {
    logic [3:0]  cmd;
    logic [7:0]  addr;
    logic [63:0] data, exp;
  } vec_t;

  word_t  in_q[$];
  reply_t exp_q[$];
  reply_t mon_e;
  vec_t   tbl[13];
  int n_vec = 0, n_err = 0, start_cnt = 0, start_cnt_b = 0, tag = 0;

  initial api_clk_in = 1'b0;
  always #5 api_clk_in = ~api_clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic refresh_head();
    if (in_q.size() == 0) begin
      api_i_empty_in = 1'b1;
    end else begin
      api_i_empty_in    = 1'b0;
      api_i_src_slot_in = in_q[0].slot;
      api_i_src_fpga_in = in_q[0].fpga;
      api_i_src_reg_in  = in_q[0].src_reg;
      api_i_tgt_reg_in  = in_q[0].tgt_reg;
      api_i_tgt_cmd_in  = in_q[0].cmd;
      api_i_data_in     = in_q[0].data;
    end
  endtask

  // Stimulus and its expected reply are queued together.
  task automatic send(input logic [3:0] cmd, input logic [7:0] addr,
                      input logic [63:0] data, input logic [63:0] exp);
    word_t  w;
    reply_t r;
    w.slot = 4'(tag); w.fpga = ~4'(tag); w.cmd = cmd;
    w.src_reg = 8'(8'h30 + tag); w.tgt_reg = addr; w.data = data;
    tag++;
    if (cmd == CMD_RD) begin
      r.slot = w.slot; r.fpga = w.fpga; r.req_reg = w.src_reg;
      r.reg_addr = addr; r.data = exp;
      exp_q.push_back(r);
    end
    in_q.push_back(w);
    refresh_head();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge api_clk_in);
    #1;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && c < 200) begin
      tick(1);
      c++;
    end
    check(name, 64'(in_q.size() + exp_q.size()), 64'd0);
    tick(3);
  endtask

  task automatic pulse_done(input logic [63:0] hi, input logic [63:0] lo);
    core_out  = {hi, lo};
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] addr, input logic [63:0] data);
    int c = 0;
    reg_b = addr; data_b = data; empty_b = 1'b0;
    while (!rd_en_b && c < 20) begin
      @(negedge api_clk_in);
      c++;
    end
    empty_b = 1'b1;
    check("auto_accept", 64'(c < 20), 64'd1);
    tick(3);
  endtask

  always @(negedge api_clk_in) begin
    if (api_i_rd_en_out && in_q.size() > 0) begin
      in_q.delete(0);
      refresh_head();
    end
    if (core_start) start_cnt++;
    if (start_b) start_cnt_b++;
    if (api_o_wr_en_out) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_reply: got reg 0x%0h data 0x%0h, required no reply",
                 api_o_src_reg_out, api_o_data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("reply_data", api_o_data_out, mon_e.data);
        check("reply_addr",
              64'({api_o_tgt_slot_out, api_o_tgt_fpga_out, api_o_tgt_reg_out,
                   api_o_src_reg_out, api_o_tgt_cmd_out, api_o_src_cmd_out}),
              64'({mon_e.slot, mon_e.fpga, mon_e.req_reg, mon_e.reg_addr, CMD_WR, CMD_WR}));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{CMD_WR,  8'd0,    64'h1122334455667788, 64'h0};
    tbl[1]  = '{CMD_WR,  8'd5,    64'hA5,               64'h0};
    tbl[2]  = '{CMD_RD,  8'd0,    64'h0,                64'h1122334455667788};
    tbl[3]  = '{CMD_RD,  8'd5,    64'h0,                64'hA5};
    tbl[4]  = '{CMD_RD,  8'h40,   64'h0,                64'h0};
    tbl[5]  = '{CMD_WR,  8'd7,    64'hDEAD,             64'h0};
    tbl[6]  = '{CMD_RD,  8'd7,    64'h0,                64'h0};
    tbl[7]  = '{CMD_RD,  8'd6,    64'h0,                64'h0};
    tbl[8]  = '{CMD_RD,  CTRL,    64'h0,                64'h0};
    tbl[9]  = '{CMD_NOP, 8'd1,    64'h55,               64'h0};
    tbl[10] = '{CMD_RD,  8'd1,    64'h0,                64'h0};
    tbl[11] = '{CMD_WR,  8'h40,   64'h77,               64'h0};
    tbl[12] = '{CMD_RD,  8'h40,   64'h0,                64'h0};

    reset = 1'b1; api_o_rfd_in = 1'b1; core_done = 1'b0; core_out = '0;
    empty_b = 1'b1; reg_b = '0; data_b = '0;
    api_i_src_slot_in = '0; api_i_src_fpga_in = '0; api_i_src_reg_in = '0;
    api_i_tgt_reg_in = '0; api_i_tgt_cmd_in = '0; api_i_data_in = '0;
    refresh_head();
    tick(3);
    check("reset_rd_en", 64'(api_i_rd_en_out), 64'd0);
    check("reset_wr_en", 64'(api_o_wr_en_out), 64'd0);
    check("reset_start", 64'(core_start), 64'd0);
    check("reset_outs", 64'({api_o_tgt_cmd_out, api_o_src_reg_out, api_o_tgt_reg_out}), 64'd0);
    check("reset_data", api_o_data_out, 64'd0);
    check("reset_core_in", 64'(|core_in), 64'd0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 13; i++) send(tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].exp);
    drain("table_drain");
    check("core_in_reg0", core_in[0 +: 64], 64'h1122334455667788);
    check("core_in_reg5", core_in[5*64 +: 64], 64'hA5);
    check("core_in_reg1_nop", core_in[64 +: 64], 64'h0);
    check("no_start_yet", 64'(start_cnt), 64'd0);

    send(CMD_WR, CTRL, 64'h1, 0);
    send(CMD_RD, CTRL, 0, 64'h1);
    drain("start_drain");
    check("start_pulse", 64'(start_cnt), 64'd1);
    tick(6);
    pulse_done(64'hBEEF, 64'hCAFE);
    send(CMD_RD, 8'd6, 0, 64'hCAFE);
    send(CMD_RD, 8'd7, 0, 64'hBEEF);
    send(CMD_RD, CTRL, 0, 64'h102);
    drain("done_drain");

    send(CMD_WR, CTRL, 64'h1, 0);
    drain("start2_drain");
    check("start2_pulse", 64'(start_cnt), 64'd2);
    send(CMD_WR, CTRL, 64'h1, 0);
    send(CMD_RD, CTRL, 0, 64'h105);
    drain("busy_start_drain");
    check("busy_no_pulse", 64'(start_cnt), 64'd2);
    send(CMD_WR, CTRL, 64'h2, 0);
    send(CMD_RD, CTRL, 0, 64'h101);
    drain("clear_drain");
    pulse_done(64'h11, 64'h22);
    pulse_done(64'h33, 64'h44);
    send(CMD_RD, CTRL, 0, 64'h202);
    send(CMD_RD, 8'd6, 0, 64'h22);
    drain("idle_done_drain");

    send(CMD_WR, CTRL, 64'h3, 0);
    send(CMD_RD, CTRL, 0, 64'h201);
    drain("clr_start_drain");
    check("clr_start_pulse", 64'(start_cnt), 64'd3);
    pulse_done(64'h0, 64'h0);

    // Start and completion land on the same edge.
    send(CMD_WR, CTRL, 64'h1, 0);
    drain("busy3_drain");
    send(CMD_WR, CTRL, 64'h1, 0);
    pulse_done(64'h66, 64'h77);
    send(CMD_RD, CTRL, 0, 64'h401);
    send(CMD_RD, 8'd6, 0, 64'h77);
    drain("same_cycle_drain");
    check("same_cycle_pulse", 64'(start_cnt), 64'd5);
    pulse_done(64'h0, 64'h0);

    api_o_rfd_in = 1'b0;
    for (int i = 0; i < 6; i++) send(CMD_RD, 8'd0, 0, 64'h1122334455667788);
    tick(20);
    check("stall_left", 64'(in_q.size()), 64'd2);
    check("stall_empty", 64'(api_i_empty_in), 64'd0);
    check("stall_rd_en", 64'(api_i_rd_en_out), 64'd0);
    api_o_rfd_in = 1'b1;
    drain("stall_drain");

    api_o_rfd_in = 1'b0;
    send(CMD_WR, 8'd0, 64'h7, 0);
    send(CMD_RD, 8'd0, 0, 64'h7);
    send(CMD_WR, 8'd0, 64'h9, 0);
    tick(15);
    check("raw_consumed", 64'(in_q.size()), 64'd0);
    api_o_rfd_in = 1'b1;
    drain("raw_drain");
    check("raw_reg0", core_in[0 +: 64], 64'h9);

    write_b(8'd4, 64'h1);
    check("auto_reg4_no_start", 64'(start_cnt_b), 64'd0);
    write_b(8'd5, 64'h2);
    check("auto_reg5_start", 64'(start_cnt_b), 64'd1);

    send(CMD_WR, CTRL, 64'h1, 0);
    drain("pre_reset_drain");
    check("pre_reset_pulse", 64'(start_cnt), 64'd6);
    api_o_rfd_in = 1'b0;
    send(CMD_RD, 8'd0, 0, 64'h9);
    send(CMD_RD, 8'd0, 0, 64'h9);
    tick(10);
    reset = 1'b1;
    tick(2);
    check("midreset_wr_en", 64'(api_o_wr_en_out), 64'd0);
    check("midreset_reg0", core_in[0 +: 64], 64'd0);
    exp_q.delete();
    reset = 1'b0;
    api_o_rfd_in = 1'b1;
    tick(10);
    pulse_done(64'hAA, 64'hBB);
    send(CMD_RD, CTRL, 0, 64'h0);
    send(CMD_RD, 8'd6, 0, 64'h0);
    drain("post_reset_drain");
    check("post_reset_no_pulse", 64'(start_cnt), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/api_regbank_ctrl.md
Name: api_regbank_ctrl

Overview:
- Parametrised host-side register bank between the SciEngines API FIFOs and a multi-cycle compute core.
- Generalises the single-core register front-end:
  - N_IN writable operand registers and N_OUT read-only result registers.
  - A control/status register.
  - Explicit start/done handshake to the core.
  - A read-response queue, so several host reads are in flight while the output port is not ready.
- Sits directly under the FPGA top, beside the user core.

Parameters:
- DATA_W, 64, width of API data and every register.
- ADDR_W, 8, width of API register address fields.
- SLOT_W, 4, API slot address width.
- FPGA_W, 4, API FPGA address width.
- CMD_W, 4, API command width; CMD_RD/CMD_WR codes come from the API constants file.
- N_IN, 6, number of operand registers (addresses 0..N_IN-1).
- N_OUT, 2, number of result registers (addresses N_IN..N_IN+N_OUT-1).
- RQ_DEPTH, 4, read-response queue entries (power of 2, >=2).
- AUTO_START, 0, if 1 a write to register N_IN-1 also issues start.

Ports:
- reset  in  1  async active-high reset
- api_clk_in  in  1  clock
- api_i_empty_in  in  1  input FIFO empty (FWFT head valid when 0)
- api_i_rd_en_out  out  1  input FIFO pop
- api_i_src_slot_in/api_i_src_fpga_in/api_i_src_reg_in  in  SLOT_W/FPGA_W/ADDR_W  requester address
- api_i_tgt_reg_in  in  ADDR_W  addressed register
- api_i_tgt_cmd_in  in  CMD_W  CMD_RD or CMD_WR
- api_i_data_in  in  DATA_W  write data
- api_o_rfd_in  in  1  output FIFO ready
- api_o_wr_en_out  out  1  output write strobe
- api_o_tgt_slot_out/api_o_tgt_fpga_out/api_o_tgt_reg_out  out  SLOT_W/FPGA_W/ADDR_W  reply destination
- api_o_src_reg_out  out  ADDR_W  register that was read
- api_o_tgt_cmd_out/api_o_src_cmd_out  out  CMD_W  constant CMD_WR
- api_o_data_out  out  DATA_W  read data
- core_start  out  1  one-cycle start pulse
- core_in  out  N_IN*DATA_W  operand regs, reg k at [k*DATA_W +: DATA_W]
- core_done  in  1  one-cycle completion pulse
- core_out  in  N_OUT*DATA_W  results, valid in core_done cycle

Behaviour:
- Reset (async, reset=1): all operand/result regs 0; rd_en, wr_en, core_start 0; all output buses 0; queue empty; status 0.
- Address CTRL = N_IN+N_OUT.
- Input side:
  - If empty_in=0, rd_en=0 and the queue is not full, process the head word and set rd_en=1 for exactly one cycle.
  - Maximum rate is one word per 2 cycles.
  - Queue full: the head is not consumed, and rd_en stays 0 until an entry drains.
- CMD_WR:
  - Addr < N_IN: operand written.
  - Addr = CTRL:
    - bit0=1 issues start.
    - bit1=1 clears the done and err sticky bits.
    - If both are set, the clear applies first, then the start.
  - Result or out-of-range address: write ignored.
  - Any other cmd code: word popped, no effect.
- CMD_RD: push {src_slot, src_fpga, src_reg, tgt_reg, data} into the queue.
  - Data is snapshotted at push time, so read-after-write order is preserved.
  - Operand reg, result reg, CTRL: returns the register value.
  - Out-of-range address: returns 0.
- Status (CTRL read) fields:
  - bit0 busy
  - bit1 done sticky
  - bit2 start_err sticky
  - [15:8] run counter mod 256
  - others 0
- Start:
  - Issued while idle: core_start=1 the next cycle, busy=1, done cleared.
  - Issued while busy: no pulse, start_err=1.
- core_done with busy=1:
  - Result regs latch core_out in the same edge.
  - busy=0, done=1, run counter +1.
- core_done with busy=0: ignored.
- core_done and a start in the same cycle: done is processed first, so the start is accepted (new pulse, busy stays 1).
- Output side:
  - If the queue is non-empty, rfd_in=1 and wr_en=0, pop the head.
  - Next cycle: wr_en=1 for one cycle with address/data fields from the entry.
  - Output fields hold their values until the next pop.
  - Maximum one reply per 2 cycles.
- Simultaneous push and pop in one cycle: both take effect; the count is unchanged.
- Read and write pointers wrap modulo RQ_DEPTH.
- Reset mid-operation: queue contents are lost, busy clears, and a later core_done is ignored.

Test Plan:
- Write reg0=0x1122334455667788, reg5=0xA5 (N_IN=6), read reg0 and reg5 → two wr_en pulses with those data, src_reg 0 then 5, tgt_reg = requester src_reg.
- Write CTRL=1 → core_start pulse once, status reads 0x1; core_done with core_out={0xBEEF,0xCAFE} after 10 cycles → reg6=0xCAFE, reg7=0xBEEF, status=0x102.
- Start while busy → no second pulse, status bit2=1; CTRL write 0x2 → status bit1 and bit2 clear.
- Hold rfd_in=0, issue 6 reads (RQ_DEPTH=4) → 4 accepted, rd_en stalls, input FIFO not empty; release rfd → 6 replies in order.
- Write reg0=7, read reg0, write reg0=9, with rfd held low → reply data is 7.
- Read addr 0x40 and write addr 7 → reply 0, reg7 unchanged; AUTO_START=1 and a write to reg5 → core_start pulse.
